// File: rtl/idmem_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
// The response tag records who owns each in-flight access.
package idmem_pkg;

    localparam int DEF_MEM_ADDR_W    = 14;
    localparam int DEF_MEM_LAT       = 1;
    localparam int DEF_MAX_LS_STREAK = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   is_store;
    } resp_tag_t;

endpackage

// File: rtl/idmem_arbiter_if.sv
// Requester and memory bus of the arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface idmem_arbiter_if #(
    parameter int ADDR_W     = 32,
    parameter int MEM_ADDR_W = 14
);
    logic                  flush_i;
    logic                  if_req_i;
    logic [ADDR_W-1:0]     if_addr_i;
    logic                  if_gnt_o;
    logic                  if_rvalid_o;
    logic [31:0]           if_rdata_o;
    logic                  ls_req_i;
    logic                  ls_we_i;
    logic [3:0]            ls_be_i;
    logic [ADDR_W-1:0]     ls_addr_i;
    logic [31:0]           ls_wdata_i;
    logic                  ls_gnt_o;
    logic                  ls_rvalid_o;
    logic [31:0]           ls_rdata_o;
    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [3:0]            mem_be_o;
    logic [MEM_ADDR_W-1:0] mem_addr_o;
    logic [31:0]           mem_wdata_o;
    logic [31:0]           mem_rdata_i;

    modport slave (
        input  flush_i, if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_be_i,
               ls_addr_i, ls_wdata_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o,
               ls_rdata_o, mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output flush_i, if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_be_i,
               ls_addr_i, ls_wdata_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o,
               ls_rdata_o, mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/idmem_resp_pipe.sv
// Owner-tag shift register matching the memory read latency.
// A flush turns every in-flight fetch tag into OWN_NONE while the tag entering stage 0 survives.
module idmem_resp_pipe
    import idmem_pkg::*;
#(
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      flush_i,
    input  resp_tag_t i_tag,
    output resp_tag_t o_tag
);

    resp_tag_t r_stage [MEM_LAT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                r_stage[i] <= '{owner: OWN_NONE, is_store: 1'b0};
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < MEM_LAT; i++) begin
                if (flush_i && r_stage[i-1].owner == OWN_IF) begin
                    r_stage[i] <= '{owner: OWN_NONE, is_store: 1'b0};
                end else begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end
    end

    assign o_tag = r_stage[MEM_LAT-1];

endmodule

// File: rtl/idmem_arbiter.sv
// Single-port memory arbiter: load/store has priority, a streak counter keeps fetch from starving,
// and a tag pipeline routes each response back to its requester.
module idmem_arbiter
    import idmem_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int MEM_ADDR_W    = DEF_MEM_ADDR_W,
    parameter int MEM_LAT       = DEF_MEM_LAT,
    parameter int MAX_LS_STREAK = DEF_MAX_LS_STREAK
) (
    input logic            clk,
    input logic            rstn,
    idmem_arbiter_if.slave bus
);

    localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);

    logic [STREAK_W-1:0] r_streak;
    logic                w_streak_full;
    logic                w_ls_win;
    logic                w_ls_gnt;
    logic                w_if_gnt;
    resp_tag_t           w_tag_in;
    resp_tag_t           w_tag_out;
    logic                w_unused;

    // Grants are forced low while reset is held so every output reads 0.
    assign w_streak_full = (r_streak == STREAK_W'(MAX_LS_STREAK));
    assign w_ls_win      = bus.ls_req_i && !(bus.if_req_i && w_streak_full);
    assign w_ls_gnt      = rstn && w_ls_win;
    assign w_if_gnt      = rstn && bus.if_req_i && !w_ls_win;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_streak <= '0;
        end else if (!bus.if_req_i || w_if_gnt) begin
            r_streak <= '0;
        end else if (w_ls_gnt && !w_streak_full) begin
            r_streak <= r_streak + 1'b1;
        end
    end

    assign bus.if_gnt_o    = w_if_gnt;
    assign bus.ls_gnt_o    = w_ls_gnt;
    assign bus.mem_en_o    = w_ls_gnt || w_if_gnt;
    assign bus.mem_we_o    = w_ls_gnt && bus.ls_we_i;
    assign bus.mem_be_o    = w_ls_gnt ? (bus.ls_we_i ? bus.ls_be_i : 4'hF) :
                             w_if_gnt ? 4'hF : 4'h0;
    assign bus.mem_addr_o  = w_ls_gnt ? bus.ls_addr_i[MEM_ADDR_W+1:2] :
                             w_if_gnt ? bus.if_addr_i[MEM_ADDR_W+1:2] : '0;
    assign bus.mem_wdata_o = w_ls_gnt ? bus.ls_wdata_i : 32'h0;

    assign w_tag_in.owner    = w_ls_gnt ? OWN_LS : (w_if_gnt ? OWN_IF : OWN_NONE);
    assign w_tag_in.is_store = w_ls_gnt && bus.ls_we_i;

    idmem_resp_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_resp_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (bus.flush_i),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out)
    );

    // A fetch leaving the pipe during a flush belongs to the old path and is dropped.
    assign bus.if_rvalid_o = (w_tag_out.owner == OWN_IF) && !bus.flush_i;
    assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : 32'h0;
    assign bus.ls_rvalid_o = (w_tag_out.owner == OWN_LS);
    assign bus.ls_rdata_o  = (bus.ls_rvalid_o && !w_tag_out.is_store) ? bus.mem_rdata_i : 32'h0;

    assign w_unused = ^{bus.if_addr_i[1:0], bus.if_addr_i[ADDR_W-1:MEM_ADDR_W+2],
                        bus.ls_addr_i[1:0], bus.ls_addr_i[ADDR_W-1:MEM_ADDR_W+2]};

endmodule

// File: tb/tb_idmem_arbiter.sv
// Bench for idmem_arbiter: a MEM_LAT=1 instance for the main traffic and a MEM_LAT=3 instance for flush.
// Expected responses are queued at issue time and popped by a monitor when rvalid appears.
module tb_idmem_arbiter;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   passCount;
    int   totalCount;

    exp_t qIf1 [$];
    exp_t qLs1 [$];
    exp_t qIf3 [$];

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] rd1;
    logic [31:0] rd3 [3];

    idmem_arbiter_if #(.ADDR_W(32), .MEM_ADDR_W(14)) bus1 ();
    idmem_arbiter_if #(.ADDR_W(32), .MEM_ADDR_W(14)) bus3 ();

    idmem_arbiter #(.ADDR_W(32), .MEM_ADDR_W(14), .MEM_LAT(1), .MAX_LS_STREAK(4)) u_dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    idmem_arbiter #(.ADDR_W(32), .MEM_ADDR_W(14), .MEM_LAT(3), .MAX_LS_STREAK(4)) u_dut3 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write-first memory models with a registered read delay equal to MEM_LAT.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 32'h0;
                mem3[i] <= 32'h0;
            end
            mem1[0]    <= 32'h0000_0013;
            mem1[1]    <= 32'h0000_0093;
            mem1[2]    <= 32'h0000_0113;
            mem1[3]    <= 32'h0000_0333;
            mem1[4]    <= 32'h0000_0044;
            mem1[8]    <= 32'h1122_3344;
            mem1[8'h40] <= 32'hCAFE_0100;
            mem1[8'h41] <= 32'h4141_4141;
            mem3[8'h10] <= 32'hAAAA_0000;
            mem3[8'h11] <= 32'hBBBB_0000;
            mem3[8'h20] <= 32'hCCCC_0080;
            rd1 <= 32'h0;
            for (int i = 0; i < 3; i++) rd3[i] <= 32'h0;
        end else begin
            if (bus1.mem_en_o && bus1.mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus1.mem_be_o[b]) mem1[bus1.mem_addr_o[7:0]][8*b +: 8] <= bus1.mem_wdata_o[8*b +: 8];
                end
            end
            rd1 <= (bus1.mem_en_o && !bus1.mem_we_o) ? mem1[bus1.mem_addr_o[7:0]] : 32'h0;
            rd3[0] <= (bus3.mem_en_o && !bus3.mem_we_o) ? mem3[bus3.mem_addr_o[7:0]] : 32'h0;
            rd3[1] <= rd3[0];
            rd3[2] <= rd3[1];
        end
    end

    assign bus1.mem_rdata_i = rd1;
    assign bus3.mem_rdata_i = rd3[2];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        totalCount++;
        if (act === expv) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                 input logic lsReq, input logic lsWe, input logic [3:0] lsBe,
                                 input logic [31:0] lsAddr, input logic [31:0] lsWdata);
        @(posedge clk);
        #1;
        bus1.if_req_i   = ifReq;
        bus1.if_addr_i  = ifAddr;
        bus1.ls_req_i   = lsReq;
        bus1.ls_we_i    = lsWe;
        bus1.ls_be_i    = lsBe;
        bus1.ls_addr_i  = lsAddr;
        bus1.ls_wdata_i = lsWdata;
        #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic tick3();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every rvalid must match the oldest queued expectation in data and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus1.if_rvalid_o) begin
            if (qIf1.size() == 0) checkOutput("if1_unexpected_rvalid", bus1.if_rvalid_o, 0);
            else begin
                e = qIf1.pop_front();
                checkOutput("if1_rdata", bus1.if_rdata_o, e.data);
                checkOutput("if1_cycle", cyc, e.cyc);
            end
        end else if (bus1.if_rdata_o != 32'h0) begin
            checkOutput("if1_rdata_idle", bus1.if_rdata_o, 0);
        end
        if (bus1.ls_rvalid_o) begin
            if (qLs1.size() == 0) checkOutput("ls1_unexpected_rvalid", bus1.ls_rvalid_o, 0);
            else begin
                e = qLs1.pop_front();
                checkOutput("ls1_rdata", bus1.ls_rdata_o, e.data);
                checkOutput("ls1_cycle", cyc, e.cyc);
            end
        end else if (bus1.ls_rdata_o != 32'h0) begin
            checkOutput("ls1_rdata_idle", bus1.ls_rdata_o, 0);
        end
        if (bus3.if_rvalid_o) begin
            if (qIf3.size() == 0) checkOutput("if3_unexpected_rvalid", bus3.if_rvalid_o, 0);
            else begin
                e = qIf3.pop_front();
                checkOutput("if3_rdata", bus3.if_rdata_o, e.data);
                checkOutput("if3_cycle", cyc, e.cyc);
            end
        end
        if (bus3.ls_rvalid_o) checkOutput("ls3_unexpected_rvalid", bus3.ls_rvalid_o, 0);
    end

    initial begin
        logic [31:0] fetchData [3];
        logic [7:0]  lsPattern;
        passCount  = 0;
        totalCount = 0;
        rstn = 1'b0;
        bus1.flush_i = 1'b0; bus1.if_req_i = 1'b0; bus1.if_addr_i = '0;
        bus1.ls_req_i = 1'b0; bus1.ls_we_i = 1'b0; bus1.ls_be_i = '0;
        bus1.ls_addr_i = '0; bus1.ls_wdata_i = '0;
        bus3.flush_i = 1'b0; bus3.if_req_i = 1'b0; bus3.if_addr_i = '0;
        bus3.ls_req_i = 1'b0; bus3.ls_we_i = 1'b0; bus3.ls_be_i = '0;
        bus3.ls_addr_i = '0; bus3.ls_wdata_i = '0;
        fetchData[0] = 32'h13;
        fetchData[1] = 32'h93;
        fetchData[2] = 32'h113;
        lsPattern    = 8'hEF;

        // Requests held during reset must not produce any grant or memory enable.
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        checkOutput("rst_grants", {bus1.if_gnt_o, bus1.ls_gnt_o, bus1.mem_en_o}, 0);
        checkOutput("rst_mem", {bus1.mem_we_o, bus1.mem_be_o, bus1.mem_addr_o, bus1.mem_wdata_o}, 0);
        checkOutput("rst_resp", {bus1.if_rvalid_o, bus1.ls_rvalid_o, bus1.if_rdata_o, bus1.ls_rdata_o}, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rstn = 1'b1;
        idle(1);

        // Fetch-only stream
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'(4 * i), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            checkOutput("fetch_gnt", {bus1.if_gnt_o, bus1.ls_gnt_o, bus1.mem_en_o}, 3'b101);
            checkOutput("fetch_addr", bus1.mem_addr_o, i);
            checkOutput("fetch_we_be", {bus1.mem_we_o, bus1.mem_be_o}, 5'b0_1111);
            qIf1.push_back('{fetchData[i], cyc + 1});
        end
        idle(1);
        checkOutput("idle_mem", {bus1.mem_en_o, bus1.mem_we_o, bus1.mem_be_o, bus1.mem_addr_o}, 0);

        // Priority: load beats fetch, fetch follows
        applyStimulus(1'b1, 32'hC, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        checkOutput("prio_gnt", {bus1.if_gnt_o, bus1.ls_gnt_o}, 2'b01);
        checkOutput("prio_addr", bus1.mem_addr_o, 14'h40);
        checkOutput("prio_be", bus1.mem_be_o, 4'hF);
        qLs1.push_back('{32'hCAFE_0100, cyc + 1});
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("prio_next_gnt", {bus1.if_gnt_o, bus1.ls_gnt_o}, 2'b10);
        checkOutput("prio_next_addr", bus1.mem_addr_o, 14'h3);
        qIf1.push_back('{32'h333, cyc + 1});
        idle(1);

        // Starvation guard: LS,LS,LS,LS,IF,LS,LS,LS
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h104, 32'h0);
            checkOutput("starve_gnt", {bus1.if_gnt_o, bus1.ls_gnt_o}, {!lsPattern[i], lsPattern[i]});
            if (lsPattern[i]) qLs1.push_back('{32'h4141_4141, cyc + 1});
            else              qIf1.push_back('{32'h44, cyc + 1});
        end
        idle(1);

        // Store acknowledge then read-after-write of the same word
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF);
        checkOutput("store_mem", {bus1.mem_en_o, bus1.mem_we_o, bus1.mem_be_o}, 6'b11_0011);
        checkOutput("store_addr", bus1.mem_addr_o, 14'h8);
        checkOutput("store_wdata", bus1.mem_wdata_o, 32'hDEAD_BEEF);
        qLs1.push_back('{32'h0, cyc + 1});
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'b0011, 32'h20, 32'h0);
        checkOutput("raw_we_be", {bus1.mem_we_o, bus1.mem_be_o}, 5'b0_1111);
        qLs1.push_back('{32'h1122_BEEF, cyc + 1});
        idle(2);

        // Flush on the MEM_LAT=3 instance
        tick3();
        bus3.if_req_i = 1'b1; bus3.if_addr_i = 32'h40;
        #3 checkOutput("flush_gnt0", bus3.if_gnt_o, 1'b1);
        tick3();
        bus3.if_addr_i = 32'h44;
        #3 checkOutput("flush_gnt1", bus3.if_gnt_o, 1'b1);
        tick3();
        bus3.if_addr_i = 32'h80; bus3.flush_i = 1'b1;
        #3 checkOutput("flush_gnt2", {bus3.if_gnt_o, bus3.mem_addr_o}, {1'b1, 14'h20});
        qIf3.push_back('{32'hCCCC_0080, cyc + 3});
        tick3();
        bus3.if_req_i = 1'b0; bus3.flush_i = 1'b0;
        #3 checkOutput("flush_rvalid_c3", bus3.if_rvalid_o, 1'b0);
        tick3();
        #3 checkOutput("flush_rvalid_c4", bus3.if_rvalid_o, 1'b0);
        idle(4);

        // Reset one cycle after a load grant drops its response
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        checkOutput("rstmid_gnt", bus1.ls_gnt_o, 1'b1);
        tick3();
        rstn = 1'b0;
        bus1.ls_req_i = 1'b0;
        #3;
        checkOutput("rstmid_resp", {bus1.ls_rvalid_o, bus1.ls_rdata_o, bus1.if_rvalid_o}, 0);
        checkOutput("rstmid_mem", {bus1.mem_en_o, bus1.mem_be_o, bus1.mem_addr_o}, 0);
        idle(2);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            checkOutput("rstmid_post_rvalid", bus1.ls_rvalid_o, 1'b0);
        end

        idle(3);
        checkOutput("if1_drain", qIf1.size(), 0);
        checkOutput("ls1_drain", qLs1.size(), 0);
        checkOutput("if3_drain", qIf3.size(), 0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
